// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file writeback definitions: address/data widths, the PC register index
// and the arbiter state encoding.
package regfile_defs;

  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_PC = 4'hF;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus between the requesters (ALU, load, branch-link) and the arbiter.
// Handshake: a beat transfers on a cycle where req_valid[i] & req_ready[i]; a requester keeps
// valid/lock/dest/data stable until it sees ready, and ready never depends on a future valid.
interface regfile_wb_arbiter_if
  import regfile_defs::*;
#(
  parameter int NUM_REQ = 3
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_lock;
  logic [REG_ADDR_W*NUM_REQ-1:0] req_dest;
  logic [DATA_W*NUM_REQ-1:0]     req_data;
  logic [NUM_REQ-1:0]            req_ready;

  modport master (
    output req_valid, req_lock, req_dest, req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_lock, req_dest, req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_picker.sv
// Combinational round-robin select: one-hot grant of the first valid requester at or after ptr_i,
// wrapping to index 0.
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    // First pass covers indices at or above the pointer, second pass the wrapped-around ones.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && valid_i[i] && (i >= int'(ptr_i))) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && valid_i[i]) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between writeback requesters, with a
// multi-beat lock (force-released after LOCK_TIMEOUT idle owner cycles) and registered write outputs.
module regfile_wb_arbiter
  import regfile_defs::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int LOCK_TIMEOUT = 8,
  localparam int GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  regfile_wb_arbiter_if.slave   req_bus,
  output logic                  writeEnable,
  output logic [REG_ADDR_W-1:0] writeDestination,
  output logic [DATA_W-1:0]     writeData,
  output logic [GW-1:0]         grant_id,
  output logic                  pc_write,
  output logic                  lock_active,
  output logic                  lock_timeout
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  arb_state_e            state_q;
  logic [GW-1:0]         rr_ptr_q;
  logic [GW-1:0]         owner_q;
  logic [CW-1:0]         cnt_q;
  logic                  we_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [DATA_W-1:0]     data_q;
  logic [GW-1:0]         gid_q;
  logic                  lock_timeout_q;

  logic [NUM_REQ-1:0]    pick;
  logic [NUM_REQ-1:0]    ready;
  logic [NUM_REQ-1:0]    hit;
  logic                  xfer;
  logic                  lock_sel;
  logic [GW-1:0]         gnt_idx;
  logic [REG_ADDR_W-1:0] gnt_dest;
  logic [DATA_W-1:0]     gnt_data;

  function automatic logic [GW-1:0] next_ptr(input logic [GW-1:0] p);
    if (int'(p) >= NUM_REQ - 1) return '0;
    return p + GW'(1);
  endfunction

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PW      (GW)
  ) u_picker (
    .valid_i (req_bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick)
  );

  // Ready is gated by reset and flush so nothing can transfer while either is active.
  always_comb begin
    ready = '0;
    if (reset && !flush) begin
      if (state_q == IDLE) begin
        ready = pick;
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (owner_q == GW'(i)) ready[i] = 1'b1;
        end
      end
    end
  end

  assign req_bus.req_ready = ready;
  assign hit      = req_bus.req_valid & ready;
  assign xfer     = |hit;
  assign lock_sel = |(hit & req_bus.req_lock);

  always_comb begin
    gnt_idx  = '0;
    gnt_dest = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hit[i]) begin
        gnt_idx  = GW'(i);
        gnt_dest = req_bus.req_dest[REG_ADDR_W*i +: REG_ADDR_W];
        gnt_data = req_bus.req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      owner_q        <= '0;
      cnt_q          <= '0;
      we_q           <= 1'b0;
      dest_q         <= '0;
      data_q         <= '0;
      gid_q          <= '0;
      lock_timeout_q <= 1'b0;
    end else begin
      we_q           <= xfer;
      lock_timeout_q <= 1'b0;
      if (xfer) begin
        dest_q <= gnt_dest;
        data_q <= gnt_data;
        gid_q  <= gnt_idx;
      end
      if (flush) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (xfer) begin
              if (lock_sel) begin
                state_q <= LOCKED;
                owner_q <= gnt_idx;
                cnt_q   <= '0;
              end else begin
                rr_ptr_q <= next_ptr(gnt_idx);
              end
            end
          end
          LOCKED: begin
            if (xfer) begin
              cnt_q <= '0;
              if (!lock_sel) begin
                state_q  <= IDLE;
                rr_ptr_q <= next_ptr(owner_q);
              end
            end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
              // This idle cycle brings the count to LOCK_TIMEOUT: drop the lock.
              state_q        <= IDLE;
              rr_ptr_q       <= next_ptr(owner_q);
              cnt_q          <= '0;
              lock_timeout_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign writeEnable      = we_q;
  assign writeDestination = dest_q;
  assign writeData        = data_q;
  assign grant_id         = gid_q;
  assign pc_write         = we_q && (dest_q == REG_PC);
  assign lock_active      = (state_q == LOCKED);
  assign lock_timeout     = lock_timeout_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (3 requesters, lock timeout of 4 idle cycles).
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        we;
  logic [3:0]  wdest;
  logic [31:0] wdata;
  logic [1:0]  gid;
  logic        pc_wr;
  logic        lk_act;
  logic        lk_to;

  logic        vld [3];
  logic        lck [3];
  logic [3:0]  dst [3];
  logic [31:0] dat [3];

  int n_vec;
  int n_err;

  regfile_wb_arbiter_if #(.NUM_REQ(3)) req_if ();

  assign req_if.req_valid = {vld[2], vld[1], vld[0]};
  assign req_if.req_lock  = {lck[2], lck[1], lck[0]};
  assign req_if.req_dest  = {dst[2], dst[1], dst[0]};
  assign req_if.req_data  = {dat[2], dat[1], dat[0]};

  regfile_wb_arbiter #(
    .NUM_REQ      (3),
    .LOCK_TIMEOUT (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .req_bus          (req_if),
    .writeEnable      (we),
    .writeDestination (wdest),
    .writeData        (wdata),
    .grant_id         (gid),
    .pc_write         (pc_wr),
    .lock_active      (lk_act),
    .lock_timeout     (lk_to)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drivers
  task automatic drive(input logic [1:0] i, input logic v, input logic l,
                       input logic [3:0] d, input logic [31:0] x);
    vld[i] = v;
    lck[i] = l;
    dst[i] = d;
    dat[i] = x;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      lck[i] = 1'b0;
      dst[i] = 4'h0;
      dat[i] = 32'h0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_wr(input string tag, input logic [3:0] d, input logic [31:0] x,
                          input logic [1:0] g);
    check({tag, ".we"},   {31'b0, we}, 32'h1);
    check({tag, ".dest"}, {28'b0, wdest}, {28'b0, d});
    check({tag, ".data"}, wdata, x);
    check({tag, ".gid"},  {30'b0, gid}, {30'b0, g});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    flush = 1'b0;
    idle_all();

    // 1. Reset with a pending request
    drive(2'd0, 1'b1, 1'b0, 4'd3, 32'h0000_1234);
    #2;
    check("rst.ready", {29'b0, req_if.req_ready}, 32'h0);
    check("rst.we",    {31'b0, we}, 32'h0);
    check("rst.dest",  {28'b0, wdest}, 32'h0);
    check("rst.data",  wdata, 32'h0);
    check("rst.gid",   {30'b0, gid}, 32'h0);
    check("rst.lkto",  {31'b0, lk_to}, 32'h0);
    check("rst.lkact", {31'b0, lk_act}, 32'h0);
    tick();
    tick();
    check("rst.hold_we",    {31'b0, we}, 32'h0);
    check("rst.hold_ready", {29'b0, req_if.req_ready}, 32'h0);
    reset = 1'b1;
    idle_all();
    tick();
    check("rel.we0", {31'b0, we}, 32'h0);
    tick();
    check("rel.we1", {31'b0, we}, 32'h0);

    // 2. Round-robin 0, 1, 0
    drive(2'd0, 1'b1, 1'b0, 4'd3, 32'hAAAA_AAAA);
    drive(2'd1, 1'b1, 1'b0, 4'd5, 32'hCCCC_CCCC);
    settle();
    check("rr.ready0", {29'b0, req_if.req_ready}, 32'h1);
    check("rr.no_we_yet", {31'b0, we}, 32'h0);
    tick();
    check_wr("rr.w0", 4'd3, 32'hAAAA_AAAA, 2'd0);
    drive(2'd0, 1'b1, 1'b0, 4'd3, 32'h1111_1111);
    settle();
    check("rr.ready1", {29'b0, req_if.req_ready}, 32'h2);
    tick();
    check_wr("rr.w1", 4'd5, 32'hCCCC_CCCC, 2'd1);
    drive(2'd1, 1'b0, 1'b0, 4'd0, 32'h0);
    settle();
    check("rr.ready2", {29'b0, req_if.req_ready}, 32'h1);
    tick();
    check_wr("rr.w2", 4'd3, 32'h1111_1111, 2'd0);
    drive(2'd0, 1'b0, 1'b0, 4'd0, 32'h0);
    tick();
    check("rr.we_off", {31'b0, we}, 32'h0);

    // 3. Lock: req1 three beats, req0 stalls
    drive(2'd0, 1'b1, 1'b0, 4'd7, 32'h7777_7777);
    drive(2'd1, 1'b1, 1'b1, 4'd4, 32'h4444_4444);
    settle();
    check("lk.ready_b0", {29'b0, req_if.req_ready}, 32'h2);
    check("lk.act_pre",  {31'b0, lk_act}, 32'h0);
    tick();
    check_wr("lk.w4", 4'd4, 32'h4444_4444, 2'd1);
    check("lk.act1", {31'b0, lk_act}, 32'h1);
    drive(2'd1, 1'b1, 1'b1, 4'd5, 32'h5555_5555);
    settle();
    check("lk.ready_b1", {29'b0, req_if.req_ready}, 32'h2);
    tick();
    check_wr("lk.w5", 4'd5, 32'h5555_5555, 2'd1);
    check("lk.act2", {31'b0, lk_act}, 32'h1);
    drive(2'd1, 1'b1, 1'b0, 4'd6, 32'h6666_6666);
    settle();
    check("lk.ready_b2", {29'b0, req_if.req_ready}, 32'h2);
    tick();
    check_wr("lk.w6", 4'd6, 32'h6666_6666, 2'd1);
    check("lk.act3", {31'b0, lk_act}, 32'h0);
    drive(2'd1, 1'b0, 1'b0, 4'd0, 32'h0);
    settle();
    check("lk.ready_r0", {29'b0, req_if.req_ready}, 32'h1);
    tick();
    check_wr("lk.w7", 4'd7, 32'h7777_7777, 2'd0);
    drive(2'd0, 1'b0, 1'b0, 4'd0, 32'h0);

    // 4. Timeout: owner goes idle for 4 cycles
    drive(2'd1, 1'b1, 1'b1, 4'd8, 32'h8888_8888);
    settle();
    check("to.ready_b0", {29'b0, req_if.req_ready}, 32'h2);
    tick();
    check_wr("to.w8", 4'd8, 32'h8888_8888, 2'd1);
    check("to.act", {31'b0, lk_act}, 32'h1);
    drive(2'd1, 1'b0, 1'b0, 4'd0, 32'h0);
    drive(2'd0, 1'b1, 1'b0, 4'd9, 32'h9999_9999);
    for (int c = 1; c <= 3; c++) begin
      settle();
      check("to.stall_ready", {29'b0, req_if.req_ready}, 32'h2);
      tick();
      check("to.no_pulse", {31'b0, lk_to}, 32'h0);
      check("to.no_we", {31'b0, we}, 32'h0);
      check("to.still_lk", {31'b0, lk_act}, 32'h1);
    end
    tick();
    check("to.pulse",    {31'b0, lk_to}, 32'h1);
    check("to.released", {31'b0, lk_act}, 32'h0);
    check("to.no_we4",   {31'b0, we}, 32'h0);
    check("to.ready_r0", {29'b0, req_if.req_ready}, 32'h1);
    tick();
    check("to.pulse_end", {31'b0, lk_to}, 32'h0);
    check_wr("to.w9", 4'd9, 32'h9999_9999, 2'd0);
    drive(2'd0, 1'b0, 1'b0, 4'd0, 32'h0);

    // 5. Flush while locked with a write already registered
    drive(2'd2, 1'b1, 1'b1, 4'd2, 32'h2222_2222);
    settle();
    check("fl.ready_r2", {29'b0, req_if.req_ready}, 32'h4);
    tick();
    check_wr("fl.w2", 4'd2, 32'h2222_2222, 2'd2);
    check("fl.lk", {31'b0, lk_act}, 32'h1);
    flush = 1'b1;
    drive(2'd0, 1'b1, 1'b0, 4'hA, 32'hAAAA_0000);
    drive(2'd2, 1'b1, 1'b1, 4'd3, 32'h3333_3333);
    settle();
    check("fl.ready", {29'b0, req_if.req_ready}, 32'h0);
    check("fl.prev_we", {31'b0, we}, 32'h1);
    tick();
    check("fl.we_off", {31'b0, we}, 32'h0);
    check("fl.lk_off", {31'b0, lk_act}, 32'h0);
    check("fl.dest_hold", {28'b0, wdest}, 32'h2);
    flush = 1'b0;
    drive(2'd2, 1'b0, 1'b0, 4'd0, 32'h0);
    settle();
    check("fl.ready_r0", {29'b0, req_if.req_ready}, 32'h1);
    tick();
    check_wr("fl.wA", 4'hA, 32'hAAAA_0000, 2'd0);
    drive(2'd0, 1'b0, 1'b0, 4'd0, 32'h0);

    // 6. PC write from branch-link
    drive(2'd2, 1'b1, 1'b0, 4'hF, 32'h0000_0100);
    settle();
    check("pc.ready", {29'b0, req_if.req_ready}, 32'h4);
    check("pc.pre", {31'b0, pc_wr}, 32'h0);
    tick();
    check("pc.pulse", {31'b0, pc_wr}, 32'h1);
    check_wr("pc.w", 4'hF, 32'h0000_0100, 2'd2);
    drive(2'd2, 1'b0, 1'b0, 4'd0, 32'h0);
    tick();
    check("pc.end", {31'b0, pc_wr}, 32'h0);
    check("pc.we_end", {31'b0, we}, 32'h0);

    // 7. Reset mid-lock abandons the sequence
    drive(2'd1, 1'b1, 1'b1, 4'd1, 32'h1010_1010);
    tick();
    check("mr.lk", {31'b0, lk_act}, 32'h1);
    drive(2'd1, 1'b1, 1'b1, 4'd2, 32'h2020_2020);
    reset = 1'b0;
    settle();
    check("mr.lk_off", {31'b0, lk_act}, 32'h0);
    check("mr.we_off", {31'b0, we}, 32'h0);
    check("mr.ready",  {29'b0, req_if.req_ready}, 32'h0);
    tick();
    idle_all();
    reset = 1'b1;
    tick();
    check("mr.no_write", {31'b0, we}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
